// File: rtl/park_transform_pkg.sv
// park_transform_pkg: shared FOC constants, FSM encoding and quarter-wave sine table generator.
package park_transform_pkg;
   localparam int FRAC       = 10;
   localparam int ROM_DEPTH  = 1024;
   localparam int ROM_W      = 10;
   localparam int ROM_AW     = $clog2(ROM_DEPTH);
   localparam int FULL_SCALE = (1 << FRAC) - 1;
   localparam longint PI_Q40 = 64'sd3454217652358;
   typedef enum logic [2:0] {S_IDLE, S_SIN, S_COS, S_MUL1, S_MUL2, S_OUT} state_t;
   // round(sin(2*pi*i/4096) * 1023) via a Q30 Taylor series, evaluated at elaboration
   function automatic logic [ROM_W-1:0] sin_q(input int i);
      longint x, x2, t, s;
      x  = (longint'(i) * PI_Q40) >>> 21;
      x2 = (x * x) >>> 30;
      t  = x;
      s  = x;
      for (int k = 1; k < 9; k++) begin
         t = -((t * x2) >>> 30) / longint'(2 * k * (2 * k + 1));
         s = s + t;
      end
      return ROM_W'((s * FULL_SCALE + (64'sd1 <<< 29)) >>> 30);
   endfunction
endpackage

// File: rtl/park_transform_sin_rom_q.sv
// sin_rom_q: 1024x10 unsigned quarter-wave sine ROM with one-cycle synchronous read.
module sin_rom_q
   import park_transform_pkg::*;
(
   input  logic              iClk,
   input  logic [ROM_AW-1:0] addr,
   output logic [ROM_W-1:0]  data
);
   logic [ROM_W-1:0] rom [ROM_DEPTH];
   for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
      localparam logic [ROM_W-1:0] V = sin_q(g);
      assign rom[g] = V;
   end
   always_ff @(posedge iClk) data <= rom[addr];
endmodule

// File: rtl/park_transform.sv
// park_transform: rotates (Ialpha, Ibeta) into (Id, Iq) using a shared quarter-wave ROM
// and two multipliers over two cycles; 5-clock latency from trigger edge to oP_done.
module park_transform
   import park_transform_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iP_en,
   input  logic signed [DATA_W-1:0] iIalpha,
   input  logic signed [DATA_W-1:0] iIbeta,
   input  logic        [11:0]       iTheta,
   output logic signed [DATA_W-1:0] oId,
   output logic signed [DATA_W-1:0] oIq,
   output logic                     oP_done
);
   localparam int TW = ROM_W + 2;
   localparam int AW = DATA_W + TW + 1;
   localparam logic signed [AW-1:0] HI = AW'((1 <<< (DATA_W - 1)) - 1);
   localparam logic signed [AW-1:0] LO = -HI - AW'(1);
   state_t st;
   logic prev;
   logic signed [DATA_W-1:0] ia, ib;
   logic [11:0] th, cth;
   logic signed [TW-1:0] s_v, c_v, c_m, trig_now;
   logic signed [AW-1:0] acc_d, acc_q, p0, p1;
   logic [ROM_AW-1:0] rom_addr;
   logic [ROM_W-1:0] rom_data;
   // odd quadrants read the table mirrored
   function automatic logic [ROM_AW-1:0] rom_idx(input logic [10:0] a);
      return a[10] ? -a[9:0] : a[9:0];
   endfunction
   function automatic logic signed [TW-1:0] trig(input logic [11:0] a, input logic [ROM_W-1:0] t);
      logic signed [TW-1:0] m;
      m = (a[10] && a[9:0] == '0) ? TW'(FULL_SCALE) : $signed({2'b00, t});
      return a[11] ? -m : m;
   endfunction
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] r;
      r = (a + AW'(1 <<< (FRAC - 1))) >>> FRAC;
      return r > HI ? DATA_W'(HI) : r < LO ? DATA_W'(LO) : DATA_W'(r);
   endfunction
   sin_rom_q u_rom (.iClk(iClk), .addr(rom_addr), .data(rom_data));
   always_comb begin
      cth      = th + 12'd1024;
      rom_addr = rom_idx(st == S_COS ? cth[10:0] : th[10:0]);
      trig_now = trig(st == S_COS ? th : cth, rom_data);
      c_m      = st == S_MUL1 ? trig_now : c_v;
      p0       = AW'(st == S_MUL1 ? ia : ib) * AW'(c_m);
      p1       = AW'(st == S_MUL1 ? ib : ia) * AW'(s_v);
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         st      <= S_IDLE;
         prev    <= 1'b0;
         ia      <= '0;
         ib      <= '0;
         th      <= '0;
         s_v     <= '0;
         c_v     <= '0;
         acc_d   <= '0;
         acc_q   <= '0;
         oId     <= '0;
         oIq     <= '0;
         oP_done <= 1'b0;
      end else begin
         prev    <= iP_en;
         oP_done <= 1'b0;
         case (st)
            S_IDLE: if (iP_en && !prev) begin
               ia <= iIalpha;
               ib <= iIbeta;
               th <= iTheta;
               st <= S_SIN;
            end
            S_SIN:  st <= S_COS;
            S_COS: begin
               s_v <= trig_now;
               st  <= S_MUL1;
            end
            S_MUL1: begin
               c_v   <= trig_now;
               acc_d <= p0 + p1;
               st    <= S_MUL2;
            end
            S_MUL2: begin
               acc_q <= p0 - p1;
               st    <= S_OUT;
            end
            S_OUT: begin
               oId     <= sat(acc_d);
               oIq     <= sat(acc_q);
               oP_done <= 1'b1;
               st      <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_park_transform.sv
// tb_park_transform: directed vectors with hand-computed Id/Iq, latency, retrigger and reset checks.
module tb_park_transform;
   logic iClk = 1'b0;
   logic iRst, iP_en, oP_done;
   logic signed [11:0] iIalpha, iIbeta, oId, oIq;
   logic [11:0] iTheta;
   int checks = 0, failures = 0, done_cnt = 0;
   int n, base;
   always #5 iClk = ~iClk;
   always @(negedge iClk) if (oP_done) done_cnt++;
   park_transform #(.DATA_W(12)) dut (
      .iClk(iClk), .iRst(iRst), .iP_en(iP_en),
      .iIalpha(iIalpha), .iIbeta(iIbeta), .iTheta(iTheta),
      .oId(oId), .oIq(oIq), .oP_done(oP_done)
   );
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge iClk);
      #1;
   endtask
   task automatic set_in(input int ia, input int ib, input int th);
      iIalpha = 12'(ia);
      iIbeta  = 12'(ib);
      iTheta  = 12'(th);
   endtask
   task automatic start(input int ia, input int ib, input int th);
      set_in(ia, ib, th);
      iP_en = 1'b1;
      tick;
      iP_en = 1'b0;
   endtask
   task automatic wait_done(output int k);
      k = 0;
      while (!oP_done && k < 20) begin
         tick;
         k++;
      end
   endtask
   initial begin
      iRst = 1'b1;
      iP_en = 1'b0;
      set_in(0, 0, 0);
      tick;
      tick;
      chk("rst_id", int'(oId), 0);
      chk("rst_iq", int'(oIq), 0);
      chk("rst_done", int'(oP_done), 0);
      iRst = 1'b0;
      tick;
      start(1000, 0, 0);
      wait_done(n);
      chk("t0_latency", n, 5);
      chk("t0_id", int'(oId), 999);
      chk("t0_iq", int'(oIq), 0);
      tick;
      chk("t0_done_fall", int'(oP_done), 0);
      start(1000, 500, 1024);
      wait_done(n);
      chk("t1024_id", int'(oId), 500);
      chk("t1024_iq", int'(oIq), -999);
      start(0, 100, 3072);
      wait_done(n);
      chk("t3072_id", int'(oId), -100);
      chk("t3072_iq", int'(oIq), 0);
      start(-2048, -2048, 512);
      wait_done(n);
      chk("t512_id_sat", int'(oId), -2048);
      chk("t512_iq", int'(oIq), 0);
      repeat (3) tick;
      chk("hold_id", int'(oId), -2048);
      base = done_cnt;
      set_in(1000, 0, 0);
      iP_en = 1'b1;
      tick;
      iP_en = 1'b0;
      set_in(77, -300, 700);
      tick;
      iP_en = 1'b1;
      tick;
      iP_en = 1'b0;
      tick;
      iP_en = 1'b1;
      tick;
      iP_en = 1'b0;
      tick;
      chk("pulse_done_e5", int'(oP_done), 1);
      chk("pulse_id", int'(oId), 999);
      chk("pulse_iq", int'(oIq), 0);
      repeat (8) tick;
      chk("pulse_done_count", done_cnt - base, 1);
      base = done_cnt;
      set_in(1000, 500, 1024);
      iP_en = 1'b1;
      tick;
      set_in(-5, 9, 2000);
      repeat (19) tick;
      iP_en = 1'b0;
      repeat (3) tick;
      chk("held_done_count", done_cnt - base, 1);
      chk("held_id", int'(oId), 500);
      chk("held_iq", int'(oIq), -999);
      start(500, 500, 1000);
      tick;
      tick;
      iRst = 1'b1;
      iP_en = 1'b1;
      set_in(300, -400, 2048);
      tick;
      chk("midrst_id", int'(oId), 0);
      chk("midrst_iq", int'(oIq), 0);
      chk("midrst_done", int'(oP_done), 0);
      base = done_cnt;
      iRst = 1'b0;
      tick;
      iP_en = 1'b0;
      wait_done(n);
      chk("postrst_latency", n, 5);
      chk("postrst_id", int'(oId), -300);
      chk("postrst_iq", int'(oIq), 400);
      tick;
      chk("postrst_done_count", done_cnt - base, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
